serial_digit_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands DIGIT bits per clock, using a DIGIT-bit ripple slice with a registered carry between cycles.
- Successor to the fixed 2-bit combinational full-adder chain. It trades latency for area in the 32-bit ALU datapath.
- Adds a start/busy/done handshake, a subtract mode, and a signed overflow flag.

---
 rtl/serial_digit_adder_if.sv | 32 +++
 rtl/serial_digit_adder.sv | 108 ++++++++++
 tb/tb_serial_digit_adder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_digit_adder_if.sv
// Handshake/data bundle between a requester and serial_digit_adder.
// Latency: none (wires only).
// Backpressure: the requester must hold off start while busy is high; a start seen then is dropped.
//
// Signals:
//   start, sub, in1, in2, cIn : request and operands, driven by the requester (master)
//   busy, done                : adder status; done is a one-cycle completion pulse
//   sum, cOut, overflow       : registered result, held until the next completion
interface serial_digit_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cOut;
    logic             overflow;

    modport master (
        output start, sub, in1, in2, cIn,
        input  busy, done, sum, cOut, overflow
    );

    modport slave (
        input  start, sub, in1, in2, cIn,
        output busy, done, sum, cOut, overflow
    );
endinterface

// File: rtl/serial_digit_adder.sv
// Multi-cycle add/subtract: a DIGIT-bit ripple slice walks the operands LSB first, carry registered between steps.
// Latency: start sampled at edge 0, busy for cycles 1..WIDTH/DIGIT, done pulses in cycle WIDTH/DIGIT+1.
// Backpressure: start is accepted only in IDLE or in the DONE cycle; a start while busy is silently dropped.
//
// Ports:
//   clk  : rising-edge clock
//   rstN : synchronous active-low reset, overrides an operation in flight
//   bus  : serial_digit_adder_if slave (start/sub/in1/in2/cIn in; busy/done/sum/cOut/overflow out)
module serial_digit_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 2
) (
    input  logic                clk,
    input  logic                rstN,
    serial_digit_adder_if.slave bus
);
    localparam int            N    = WIDTH / DIGIT;
    localparam int            CW   = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   slice;
    logic             c_msb;
    logic [WIDTH-1:0] acc_next;

    // One digit of the ripple adder: {carry out, DIGIT sum bits}.
    assign slice = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

    // Carry into the top bit of the slice, recovered from s = a ^ b ^ cin.
    // On the last step this is the carry into the operand MSB.
    assign c_msb = slice[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];

    // New digit enters at the top of the result register, older digits move down.
    generate
        if (DIGIT == WIDTH) begin : g_full
            assign acc_next = slice[DIGIT-1:0];
        end else begin : g_part
            assign acc_next = {slice[DIGIT-1:0], acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state        <= IDLE;
            opa          <= '0;
            opb          <= '0;
            acc          <= '0;
            carry        <= 1'b0;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.sum      <= '0;
            bus.cOut     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        // Subtract is a + ~b + 1; the +1 rides in on the initial carry.
                        opa      <= bus.in1;
                        opb      <= bus.sub ? ~bus.in2 : bus.in2;
                        carry    <= bus.sub ? 1'b1 : bus.cIn;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    acc   <= acc_next;
                    carry <= slice[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Visible outputs change only here, so the previous
                        // result stays readable for the whole run.
                        bus.sum      <= acc_next;
                        bus.cOut     <= slice[DIGIT];
                        bus.overflow <= slice[DIGIT] ^ c_msb;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder: four instances (DIGIT = 1, 2, 8, 32; WIDTH = 32) share one stimulus.
// Latency of each instance is measured against WIDTH/DIGIT+1 and results against an arithmetic reference.
// Directed corner cases first, then reset/handshake timing, then randomized operations.
module tb_serial_digit_adder;
    localparam int W = 32;

    logic          clk;
    logic          rstN;
    logic          start;
    logic          sub;
    logic          cIn;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;

    logic [3:0]    busy_v;
    logic [3:0]    done_v;
    logic [3:0]    cout_v;
    logic [3:0]    ovf_v;
    logic [W-1:0]  sum_v [4];

    int ncyc_t [4] = '{32, 16, 4, 1};
    int ncmp = 0;
    int nerr = 0;

    serial_digit_adder_if #(.WIDTH(W)) bus [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 32;
        assign bus[g].start = start;
        assign bus[g].sub   = sub;
        assign bus[g].in1   = in1;
        assign bus[g].in2   = in2;
        assign bus[g].cIn   = cIn;
        assign busy_v[g]    = bus[g].busy;
        assign done_v[g]    = bus[g].done;
        assign cout_v[g]    = bus[g].cOut;
        assign ovf_v[g]     = bus[g].overflow;
        assign sum_v[g]     = bus[g].sum;

        serial_digit_adder #(.WIDTH(W), .DIGIT(D)) dut (
            .clk  (clk),
            .rstN (rstN),
            .bus  (bus[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic. {cOut,sum} is the 33-bit unsigned result,
    // overflow means the signed result falls outside the 32-bit signed range.
    function automatic logic [33:0] model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                          input logic ci);
        longint    ur;
        longint    sr;
        logic [63:0] u;
        logic      ov;
        if (s) begin
            ur = longint'(a) + 64'sh1_0000_0000 - longint'(b);
            sr = longint'(signed'(a)) - longint'(signed'(b));
        end else begin
            ur = longint'(a) + longint'(b) + longint'(ci);
            sr = longint'(signed'(a)) + longint'(signed'(b)) + longint'(ci);
        end
        u  = ur;
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {u[32], u[31:0], ov};
    endfunction

    function automatic logic [33:0] result(input int i);
        return {cout_v[i], sum_v[i], ovf_v[i]};
    endfunction

    // Launch one operation on all instances from an idle state and watch them for 34 cycles.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input logic [33:0] exp, input string tag);
        int          lat [4];
        int          ndone [4];
        bit          busy_ok [4];
        logic [33:0] got [4];
        for (int i = 0; i < 4; i++) begin
            lat[i] = -1; ndone[i] = 0; busy_ok[i] = 1'b1; got[i] = '0;
        end
        start = 1'b1; sub = s; in1 = a; in2 = b; cIn = ci;
        @(negedge clk);
        // Scramble operands after the start edge: they must not matter any more.
        start = 1'b0; sub = $urandom_range(1); cIn = $urandom_range(1);
        in1 = $urandom; in2 = $urandom;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (busy_v[i] !== (cyc <= ncyc_t[i])) busy_ok[i] = 1'b0;
                if (done_v[i] === 1'b1) begin
                    ndone[i]++;
                    lat[i] = cyc;
                    got[i] = result(i);
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s latency d%0d", tag, i), (ndone[i] == 1) ? lat[i] : -2, ncyc_t[i] + 1);
            chk($sformatf("%s result d%0d", tag, i), got[i], exp);
            chk($sformatf("%s busy d%0d", tag, i), busy_ok[i], 1'b1);
        end
    endtask

    initial begin
        logic [33:0] exp_a;
        logic [33:0] exp_b;
        bit          ok;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] corner [4];
        logic        rs;
        logic        rc;

        corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;

        rstN = 1'b0; start = 1'b0; sub = 1'b0; cIn = 1'b0; in1 = '0; in2 = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk($sformatf("reset outputs d%0d", i),
                {busy_v[i], done_v[i], cout_v[i], sum_v[i], ovf_v[i]}, 36'h0);
        rstN = 1'b1;
        @(negedge clk);

        // Directed arithmetic corners.
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 32'h0000_0000, 1'b0}, "wrap");
        run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 32'h8000_0000, 1'b1}, "posovf");
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 32'h0000_0000, 1'b1}, "negovf");
        run_op(1'b1, 32'd5, 32'd7, 1'b0, {1'b0, 32'hFFFF_FFFE, 1'b0}, "sub5m7");
        run_op(1'b1, 32'd7, 32'd5, 1'b0, {1'b1, 32'h0000_0002, 1'b0}, "sub7m5");
        run_op(1'b1, 32'd7, 32'd5, 1'b1, {1'b1, 32'h0000_0002, 1'b0}, "sub_cin1");
        run_op(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b1, {1'b0, 32'h0000_0031, 1'b0}, "add_cin1");

        // Start while busy is dropped; start in the DONE cycle is taken (DIGIT=2 instance).
        exp_a = {1'b0, 32'h2345_6789, 1'b0};
        exp_b = {1'b1, 32'h0000_00FF, 1'b0};
        start = 1'b1; sub = 1'b0; in1 = 32'h1234_5678; in2 = 32'h1111_1111; cIn = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (cyc == 5) begin
                start = 1'b1; sub = 1'b1; in1 = 32'h0000_0100; in2 = 32'h0000_0001;
            end else begin
                start = 1'b0;
            end
            if (done_v[1] !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk("ignored start no early done", ok, 1'b1);
        chk("ignored start done at 17", done_v[1], 1'b1);
        chk("ignored start result", result(1), exp_a);
        start = 1'b1; sub = 1'b1; in1 = 32'h0000_0100; in2 = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (result(1) !== exp_a || done_v[1] !== 1'b0 || busy_v[1] !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        chk("b2b old result held", ok, 1'b1);
        chk("b2b done at 17", done_v[1], 1'b1);
        chk("b2b result", result(1), exp_b);
        repeat (2) @(negedge clk);

        // Reset in the middle of a run.
        start = 1'b1; sub = 1'b0; in1 = 32'hDEAD_BEEF; in2 = 32'h0102_0304; cIn = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk($sformatf("midrun reset d%0d", i),
                {busy_v[i], done_v[i], cout_v[i], sum_v[i], ovf_v[i]}, 36'h0);
        rstN = 1'b1;
        ok = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done_v !== 4'b0 || busy_v !== 4'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk("no done after reset", ok, 1'b1);
        run_op(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0, {1'b0, 32'h0000_0007, 1'b0}, "post_reset");

        // Randomized operations, operands sometimes drawn from the sign/wrap corners.
        for (int n = 0; n < 240; n++) begin
            ra = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
            rb = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
            rs = $urandom_range(1);
            rc = $urandom_range(1);
            run_op(rs, ra, rb, rc, model(rs, ra, rb, rc), $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
